// File: rtl/spi_flash_responder.sv
// spi_flash_responder
//   SPI mode-0 slave that impersonates a serial NOR flash. It answers READ (0x03),
//   JEDEC ID (0x9F) and READ STATUS (0x05), serving READ data from a byte-wide
//   synchronous memory with one cycle of read latency. SCK, CS# and MOSI are
//   oversampled in the clk domain, so each SCK phase must last at least 4 clk periods.
//
// Ports
//   clk         system clock, rising edge
//   rst_i       asynchronous active-high reset
//   cs_n_i      chip select from the master (active-low, asynchronous)
//   sck_i       SPI clock from the master (asynchronous)
//   mosi_i      serial data in, MSB first
//   miso_o      serial data out, MSB first; 0 whenever no response is being shifted
//   mem_addr_o  byte address to the backing memory
//   mem_rd_o    single-cycle read strobe
//   mem_data_i  read data, valid one cycle after mem_rd_o
//   busy_o      high while the synchronised CS# is low

module spi_flash_responder #(
    parameter int unsigned ADDR_WIDTH = 22,  // 2..24
    parameter logic [23:0] JEDEC_ID   = 24'hEF4016,
    parameter logic [7:0]  STATUS_VAL = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  cs_n_i,
    input  logic                  sck_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_rd_o,
    input  logic [7:0]            mem_data_i,
    output logic                  busy_o
);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StData,
        StId,
        StStat,
        StIgnore
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronisers plus one extra stage for edge detection
    // ------------------------------------------------------------------
    logic [1:0] cs_sync_q;
    logic [1:0] sck_sync_q;
    logic [1:0] mosi_sync_q;
    logic       cs_prev_q;
    logic       sck_prev_q;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            // CS# resets to its inactive level so reset never looks like a select
            cs_sync_q   <= 2'b11;
            sck_sync_q  <= 2'b00;
            mosi_sync_q <= 2'b00;
            cs_prev_q   <= 1'b1;
            sck_prev_q  <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[0], cs_n_i};
            sck_sync_q  <= {sck_sync_q[0], sck_i};
            mosi_sync_q <= {mosi_sync_q[0], mosi_i};
            cs_prev_q   <= cs_sync_q[1];
            sck_prev_q  <= sck_sync_q[1];
        end
    end

    logic cs_s, sck_s, mosi_s;
    logic cs_fall, sck_rise, sck_fall;

    assign cs_s     = cs_sync_q[1];
    assign sck_s    = sck_sync_q[1];
    assign mosi_s   = mosi_sync_q[1];
    assign cs_fall  = ~cs_s & cs_prev_q;
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;

    // ------------------------------------------------------------------
    // Protocol FSM
    // ------------------------------------------------------------------
    state_e                state_q;
    logic [2:0]            bit_cnt_q;
    logic [1:0]            byte_cnt_q;  // saturates at 3; enough for command+address and ID
    logic [7:0]            sin_q;
    logic [7:0]            sout_q;
    logic [ADDR_WIDTH-1:0] addr_q;      // keeps only the low ADDR_WIDTH address bits
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  mem_rd_q;
    logic                  rd_pend_q;   // read data arrives this cycle
    logic                  miso_q;
    logic                  busy_q;

    logic [7:0]            byte_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic                  shifting;

    assign byte_nxt = {sin_q[6:0], mosi_s};
    assign addr_nxt = {addr_q[ADDR_WIDTH-2:0], mosi_s};
    assign shifting = (state_q == StData) || (state_q == StId) || (state_q == StStat);

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 2'd0;
            sin_q      <= 8'h00;
            sout_q     <= 8'h00;
            addr_q     <= '0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            rd_pend_q  <= 1'b0;
            miso_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            mem_rd_q  <= 1'b0;
            rd_pend_q <= 1'b0;
            if (cs_s) begin
                // Deselect overrides everything, including an SCK edge seen this cycle
                state_q    <= StIdle;
                bit_cnt_q  <= 3'd0;
                byte_cnt_q <= 2'd0;
                sout_q     <= 8'h00;
                miso_q     <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                busy_q    <= 1'b1;
                rd_pend_q <= mem_rd_q;
                if (rd_pend_q && state_q == StData) begin
                    sout_q <= mem_data_i;
                end

                if (state_q == StIdle) begin
                    if (cs_fall) begin
                        state_q <= StCmd;
                    end
                end else if (sck_rise) begin
                    sin_q     <= byte_nxt;
                    addr_q    <= addr_nxt;
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (byte_cnt_q != 2'd3) begin
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                        end
                        case (state_q)
                            StCmd: begin
                                case (byte_nxt)
                                    8'h03:   state_q <= StAddr;
                                    8'h9F: begin
                                        state_q <= StId;
                                        sout_q  <= JEDEC_ID[23:16];
                                    end
                                    8'h05: begin
                                        state_q <= StStat;
                                        sout_q  <= STATUS_VAL;
                                    end
                                    default: state_q <= StIgnore;
                                endcase
                            end
                            StAddr: begin
                                // byte_cnt is 1..3 for the three address bytes
                                if (byte_cnt_q == 2'd3) begin
                                    mem_addr_q <= addr_nxt;
                                    mem_rd_q   <= 1'b1;
                                    state_q    <= StData;
                                end
                            end
                            StData: begin
                                // Prefetch the next byte; it loads well before the next fall
                                mem_addr_q <= mem_addr_q + 1'b1;
                                mem_rd_q   <= 1'b1;
                            end
                            StId: begin
                                case (byte_cnt_q)
                                    2'd1:    sout_q <= JEDEC_ID[15:8];
                                    2'd2:    sout_q <= JEDEC_ID[7:0];
                                    default: sout_q <= 8'h00;
                                endcase
                            end
                            StStat:  sout_q <= STATUS_VAL;
                            default: ;
                        endcase
                    end
                end else if (sck_fall && shifting) begin
                    miso_q <= sout_q[7];
                    sout_q <= {sout_q[6:0], 1'b0};
                end
            end
        end
    end

    assign miso_o     = miso_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_rd_o   = mem_rd_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
module tb_spi_flash_responder;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        cs_n_i;
    logic        sck_i;
    logic        mosi_i;
    logic        miso_o;
    logic [21:0] mem_addr_o;
    logic        mem_rd_o;
    logic [7:0]  mem_data_i;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    spi_flash_responder dut (
        .clk        (clk),
        .rst_i      (rst_i),
        .cs_n_i     (cs_n_i),
        .sck_i      (sck_i),
        .mosi_i     (mosi_i),
        .miso_o     (miso_o),
        .mem_addr_o (mem_addr_o),
        .mem_rd_o   (mem_rd_o),
        .mem_data_i (mem_data_i),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    // Backing memory: mem[i] = i[7:0], one cycle of read latency
    always @(posedge clk) begin
        if (mem_rd_o) mem_data_i <= mem_addr_o[7:0];
    end

    // Log of every read strobe and its address
    logic [21:0] rd_log [64];
    int          rd_total = 0;
    always @(posedge clk) begin
        if (mem_rd_o) begin
            rd_log[rd_total % 64] <= mem_addr_o;
            rd_total              <= rd_total + 1;
        end
    end

    typedef struct {
        string       name;
        logic [63:0] tx;      // bytes sent, left-justified
        logic [63:0] exp;     // expected MISO bytes at the same positions
        int          n;       // bytes in the transfer
        int          first;   // first byte position whose MISO is checked
        int          half;    // clk periods per SCK phase
        bit          simul;   // raise CS# together with the final SCK rise
        int          exp_rd;  // expected read strobes
        logic [21:0] a_first;
        logic [21:0] a_last;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One mode-0 bit: MOSI set while SCK low, MISO sampled just before the rise
    task automatic spi_bit(input logic b, input int half, input bit end_cs, output logic r);
        mosi_i = b;
        wait_clk(half);
        r     = miso_o;
        sck_i = 1'b1;
        if (end_cs) cs_n_i = 1'b1;
        wait_clk(half);
        sck_i = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, input int half, input bit end_cs,
                            output logic [7:0] rx);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], half, end_cs && (i == 0), r);
            rx[i] = r;
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] rx;
        int         rd0;
        rd0    = rd_total;
        cs_n_i = 1'b0;
        wait_clk(v.half);
        for (int i = 0; i < v.n; i++) begin
            spi_byte(v.tx[63-8*i -: 8], v.half, v.simul && (i == v.n - 1), rx);
            if (i == 0) check({v.name, " busy"}, 32'(busy_o), 32'd1);
            if (i >= v.first) check($sformatf("%s byte%0d", v.name, i), 32'(rx),
                                    32'(v.exp[63-8*i -: 8]));
        end
        if (!v.simul) begin
            wait_clk(v.half);
            cs_n_i = 1'b1;
        end
        wait_clk(8);
        check({v.name, " rd count"}, 32'(rd_total - rd0), 32'(v.exp_rd));
        if (v.exp_rd > 0) begin
            check({v.name, " first addr"}, 32'(rd_log[rd0 % 64]), 32'(v.a_first));
            check({v.name, " last addr"}, 32'(rd_log[(rd_total - 1) % 64]), 32'(v.a_last));
            check({v.name, " mem_addr_o"}, 32'(mem_addr_o), 32'(v.a_last));
        end
        check({v.name, " idle busy"}, 32'(busy_o), 32'd0);
    endtask

    vec_t vecs [6];
    vec_t stat_v;
    vec_t jedec_v;

    initial begin
        logic       r;
        logic [7:0] rx;
        int         rd0;

        jedec_v = '{"jedec", 64'h9F00_0000_0000_0000, 64'h00EF_4016_0000_0000, 5, 1, 6, 1'b0,
                    0, 22'h0, 22'h0};
        stat_v  = '{"stat", 64'h0500_0000_0000_0000, 64'h0, 3, 1, 6, 1'b0, 0, 22'h0, 22'h0};
        vecs[0] = jedec_v;
        vecs[1] = '{"read", 64'h0300_0010_0000_0000, 64'h0000_0000_1011_1213, 8, 4, 6, 1'b1,
                    4, 22'h000010, 22'h000013};
        vecs[2] = stat_v;
        vecs[3] = '{"unknown", 64'hABFF_FF00_0000_0000, 64'h0, 3, 1, 6, 1'b0, 0, 22'h0, 22'h0};
        vecs[4] = '{"wrap", 64'h033F_FFFF_0000_0000, 64'h0000_0000_FF00_0000, 6, 4, 6, 1'b1,
                    2, 22'h3FFFFF, 22'h000000};
        vecs[5] = '{"read fast", 64'h0300_0010_0000_0000, 64'h0000_0000_1011_1213, 8, 4, 4, 1'b1,
                    4, 22'h000010, 22'h000013};

        rst_i  = 1'b1;
        cs_n_i = 1'b1;
        sck_i  = 1'b0;
        mosi_i = 1'b0;
        wait_clk(3);
        check("reset miso", 32'(miso_o), 32'd0);
        check("reset mem_rd", 32'(mem_rd_o), 32'd0);
        check("reset mem_addr", 32'(mem_addr_o), 32'd0);
        check("reset busy", 32'(busy_o), 32'd0);
        rst_i = 1'b0;
        wait_clk(4);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Abort after 12 address bits: no memory access, then STATUS still works
        rd0    = rd_total;
        cs_n_i = 1'b0;
        wait_clk(6);
        spi_byte(8'h03, 6, 1'b0, rx);
        for (int i = 0; i < 12; i++) spi_bit(1'b1, 6, 1'b0, r);
        wait_clk(6);
        cs_n_i = 1'b1;
        wait_clk(8);
        check("abort rd count", 32'(rd_total - rd0), 32'd0);
        check("abort busy", 32'(busy_o), 32'd0);
        check("abort miso", 32'(miso_o), 32'd0);
        run_vec(stat_v);

        // Asynchronous reset in the middle of a JEDEC response
        cs_n_i = 1'b0;
        wait_clk(6);
        spi_byte(8'h9F, 6, 1'b0, rx);
        spi_bit(1'b0, 6, 1'b0, r);
        check("mid-id first bit", 32'(r), 32'd1);
        wait_clk(4);
        check("mid-id miso", 32'(miso_o), 32'd1);
        check("mid-id busy", 32'(busy_o), 32'd1);
        rst_i = 1'b1;
        #1;
        check("async rst miso", 32'(miso_o), 32'd0);
        check("async rst mem_rd", 32'(mem_rd_o), 32'd0);
        check("async rst mem_addr", 32'(mem_addr_o), 32'd0);
        check("async rst busy", 32'(busy_o), 32'd0);
        cs_n_i = 1'b1;
        sck_i  = 1'b0;
        wait_clk(3);
        rst_i = 1'b0;
        wait_clk(4);
        run_vec(jedec_v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit
    initial begin
        #2000000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule
